// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 pipeline sequencing controller.
package msrv32_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'd0;
    localparam state_t ST_MEM_WAIT = 2'd1;
    localparam state_t ST_FLUSH    = 2'd2;

    localparam int FLUSH_CYCLES_MAX = 15;
    localparam int CNT_W            = 4;

endpackage

// File: rtl/msrv32_wait_timer.sv
// Counts consecutive data-memory wait cycles and flags when the count saturates.
// Present only when MSRV32_MEM_TIMEOUT_EN is defined.
`ifdef MSRV32_MEM_TIMEOUT_EN
module msrv32_wait_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk_in,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TIMEOUT_W-1:0] count_q;

    assign expire = &count_q;

    always_ff @(posedge clk_in) begin
        if (clear)
            count_q <= '0;
        else if (enable && !expire)
            count_q <= count_q + 1'b1;
    end

endmodule
`endif

// File: rtl/msrv32_pipe_ctrl.sv
// Stall/flush sequencing for the msrv32 pipeline: branches, traps, dmem waits, load-use.
// Optional memory-wait timeout enabled by defining MSRV32_MEM_TIMEOUT_EN.
module msrv32_pipe_ctrl
    import msrv32_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT_W    = 8
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       branch_taken_in,
    input  logic       trap_taken_in,
    input  logic       dmem_req_in,
    input  logic       dmem_ready_in,
    input  logic       imem_ready_in,
    input  logic       load_use_in,
    output logic       pc_en_out,
    output logic       reg1_en_out,
    output logic       reg1_flush_out,
    output logic       reg2_en_out,
    output logic       reg2_flush_out,
    output logic       trap_ack_out,
    output logic [1:0] state_out,
    output logic       mem_timeout_out
);

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > FLUSH_CYCLES_MAX) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES out of range 1..15");
    end
    if (TIMEOUT_W < 1) begin : g_bad_timeout_w
        $error("TIMEOUT_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_RELOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic             MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trap_pend_q, trap_pend_d;
    logic               trap_req, redir, timer_expire;

    assign state_out = state_q;
    assign trap_req  = trap_taken_in | trap_pend_q;
    assign redir     = trap_req | branch_taken_in;

`ifdef MSRV32_MEM_TIMEOUT_EN
    msrv32_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
        .clk_in (clk_in),
        .clear  (!reset_in || state_q != ST_MEM_WAIT),
        .enable (state_q == ST_MEM_WAIT),
        .expire (timer_expire)
    );
`else
    assign timer_expire = 1'b0;
`endif

    always_comb begin
        pc_en_out       = 1'b0;
        reg1_en_out     = 1'b0;
        reg1_flush_out  = 1'b0;
        reg2_en_out     = 1'b0;
        reg2_flush_out  = 1'b0;
        trap_ack_out    = 1'b0;
        mem_timeout_out = 1'b0;
        state_d         = state_q;
        cnt_d           = cnt_q;
        trap_pend_d     = trap_pend_q;

        case (state_q)
            ST_RUN: begin
                if (redir) begin
                    pc_en_out      = 1'b1;
                    reg1_en_out    = 1'b1;
                    reg1_flush_out = 1'b1;
                    reg2_en_out    = 1'b1;
                    reg2_flush_out = 1'b1;
                    trap_ack_out   = trap_req;
                    trap_pend_d    = 1'b0;
                    cnt_d          = CNT_RELOAD;
                    state_d        = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
                end else if (dmem_req_in && !dmem_ready_in) begin
                    state_d = ST_MEM_WAIT;
                end else if (load_use_in) begin
                    reg2_en_out    = 1'b1;
                    reg2_flush_out = 1'b1;
                end else if (!imem_ready_in) begin
                    reg1_en_out    = 1'b1;
                    reg1_flush_out = 1'b1;
                    reg2_en_out    = 1'b1;
                end else begin
                    pc_en_out   = 1'b1;
                    reg1_en_out = 1'b1;
                    reg2_en_out = 1'b1;
                end
            end
            // Branches are dropped while frozen; a trap is remembered for the next RUN cycle.
            ST_MEM_WAIT: begin
                if (trap_taken_in)
                    trap_pend_d = 1'b1;
                if (dmem_ready_in) begin
                    pc_en_out   = 1'b1;
                    reg1_en_out = 1'b1;
                    reg2_en_out = 1'b1;
                    state_d     = ST_RUN;
                end else if (timer_expire) begin
                    mem_timeout_out = 1'b1;
                    cnt_d           = CNT_RELOAD;
                    state_d         = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                reg1_en_out    = 1'b1;
                reg1_flush_out = 1'b1;
                reg2_en_out    = 1'b1;
                reg2_flush_out = 1'b1;
                if (redir) begin
                    pc_en_out    = 1'b1;
                    trap_ack_out = trap_req;
                    trap_pend_d  = 1'b0;
                    cnt_d        = CNT_RELOAD;
                    state_d      = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
                end else begin
                    pc_en_out = imem_ready_in;
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                cnt_d       = '0;
                trap_pend_d = 1'b0;
                state_d     = ST_RUN;
            end
        endcase

        // Reset holds the front end and keeps NOPs flowing into both stages.
        if (!reset_in) begin
            pc_en_out       = 1'b0;
            reg1_en_out     = 1'b1;
            reg1_flush_out  = 1'b1;
            reg2_en_out     = 1'b1;
            reg2_flush_out  = 1'b1;
            trap_ack_out    = 1'b0;
            mem_timeout_out = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            trap_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trap_pend_q <= trap_pend_d;
        end
    end

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Directed-vector scoreboard bench for msrv32_pipe_ctrl (FLUSH_CYCLES=2, TIMEOUT_W=3).
module tb_msrv32_pipe_ctrl;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b0;
    logic       branch_taken_in = 1'b0, trap_taken_in = 1'b0;
    logic       dmem_req_in = 1'b0, dmem_ready_in = 1'b0;
    logic       imem_ready_in = 1'b1, load_use_in = 1'b0;
    logic       pc_en_out, reg1_en_out, reg1_flush_out, reg2_en_out, reg2_flush_out;
    logic       trap_ack_out, mem_timeout_out;
    logic [1:0] state_out;

    always #5 clk_in = ~clk_in;

    msrv32_pipe_ctrl #(.FLUSH_CYCLES(2), .TIMEOUT_W(3)) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .branch_taken_in (branch_taken_in),
        .trap_taken_in   (trap_taken_in),
        .dmem_req_in     (dmem_req_in),
        .dmem_ready_in   (dmem_ready_in),
        .imem_ready_in   (imem_ready_in),
        .load_use_in     (load_use_in),
        .pc_en_out       (pc_en_out),
        .reg1_en_out     (reg1_en_out),
        .reg1_flush_out  (reg1_flush_out),
        .reg2_en_out     (reg2_en_out),
        .reg2_flush_out  (reg2_flush_out),
        .trap_ack_out    (trap_ack_out),
        .state_out       (state_out),
        .mem_timeout_out (mem_timeout_out)
    );

    // Stimulus word: {reset_in, branch, trap, dmem_req, dmem_ready, imem_ready, load_use}
    localparam logic [6:0] IN_RST   = 7'b0_0_0_0_0_1_0;
    localparam logic [6:0] IN_IDLE  = 7'b1_0_0_0_0_1_0;
    localparam logic [6:0] IN_BR    = 7'b1_1_0_0_0_1_0;
    localparam logic [6:0] IN_TR    = 7'b1_0_1_0_0_1_0;
    localparam logic [6:0] IN_BT    = 7'b1_1_1_0_0_1_0;
    localparam logic [6:0] IN_LU    = 7'b1_0_0_0_0_1_1;
    localparam logic [6:0] IN_IMW   = 7'b1_0_0_0_0_0_0;
    localparam logic [6:0] IN_DST   = 7'b1_0_0_1_0_1_0;
    localparam logic [6:0] IN_DSTT  = 7'b1_0_1_1_0_1_0;
    localparam logic [6:0] IN_DRDYT = 7'b1_0_1_1_1_1_0;
    localparam logic [6:0] IN_DRDY  = 7'b1_0_0_1_1_1_0;
    localparam logic [6:0] IN_DSTLU = 7'b1_0_0_1_0_1_1;
    localparam logic [6:0] IN_BRDST = 7'b1_1_0_1_0_1_0;

    // Expected word: {pc_en, reg1_en, reg1_flush, reg2_en, reg2_flush, trap_ack, state[1:0], mem_timeout}
    localparam logic [8:0] EX_N    = 9'b1_1_0_1_0_0_00_0;
    localparam logic [8:0] EX_FL0  = 9'b1_1_1_1_1_0_00_0;
    localparam logic [8:0] EX_FLA  = 9'b1_1_1_1_1_1_00_0;
    localparam logic [8:0] EX_FL2  = 9'b1_1_1_1_1_0_10_0;
    localparam logic [8:0] EX_FL2N = 9'b0_1_1_1_1_0_10_0;
    localparam logic [8:0] EX_S0   = 9'b0_0_0_0_0_0_00_0;
    localparam logic [8:0] EX_S1   = 9'b0_0_0_0_0_0_01_0;
    localparam logic [8:0] EX_RDY1 = 9'b1_1_0_1_0_0_01_0;
    localparam logic [8:0] EX_LU   = 9'b0_0_0_1_1_0_00_0;
    localparam logic [8:0] EX_IMW  = 9'b0_1_1_1_0_0_00_0;
    localparam logic [8:0] EX_RST0 = 9'b0_1_1_1_1_0_00_0;
    localparam logic [8:0] EX_RST1 = 9'b0_1_1_1_1_0_01_0;
    localparam logic [8:0] EX_TO   = 9'b0_0_0_0_0_0_01_1;

    typedef struct {
        int         id;
        logic [8:0] exp;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         step_id = 0;
    logic [8:0] got;

    assign got = {pc_en_out, reg1_en_out, reg1_flush_out, reg2_en_out, reg2_flush_out,
                  trap_ack_out, state_out, mem_timeout_out};

    task automatic cyc(input logic [6:0] stim, input logic [8:0] exp, input bit chk);
        exp_t e;
        @(posedge clk_in);
        #1;
        {reset_in, branch_taken_in, trap_taken_in, dmem_req_in,
         dmem_ready_in, imem_ready_in, load_use_in} = stim;
        step_id++;
        if (chk) begin
            e.id  = step_id;
            e.exp = exp;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL step %0d outputs {pc,e1,f1,e2,f2,ack,st,to}: got %b required %b",
                         e.id, got, e.exp);
            end
        end
    end

    initial begin
        repeat (3) cyc(IN_RST, EX_RST0, 1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_BR,    EX_FL0,  1'b1);
        cyc(IN_IDLE,  EX_FL2,  1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_LU,    EX_LU,   1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_IMW,   EX_IMW,  1'b1);
        cyc(IN_DST,   EX_S0,   1'b1);
        cyc(IN_DST,   EX_S1,   1'b1);
        cyc(IN_DSTT,  EX_S1,   1'b1);
        cyc(IN_DSTT,  EX_S1,   1'b1);
        cyc(IN_DRDYT, EX_RDY1, 1'b1);
        cyc(IN_TR,    EX_FLA,  1'b1);
        cyc(IN_IDLE,  EX_FL2,  1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_BT,    EX_FLA,  1'b1);
        cyc(IN_IDLE,  EX_FL2,  1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_DRDY,  EX_N,    1'b1);
        cyc(IN_BR,    EX_FL0,  1'b1);
        cyc(IN_IMW,   EX_FL2N, 1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_BR,    EX_FL0,  1'b1);
        cyc(IN_BR,    EX_FL2,  1'b1);
        cyc(IN_IDLE,  EX_FL2,  1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_BRDST, EX_FL0,  1'b1);
        cyc(IN_IDLE,  EX_FL2,  1'b1);
        cyc(IN_DSTLU, EX_S0,   1'b1);
        cyc(IN_DRDY,  EX_RDY1, 1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_DST,   EX_S0,   1'b1);
        cyc(IN_DSTT,  EX_S1,   1'b1);
        cyc(IN_RST,   EX_RST1, 1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
`ifdef MSRV32_MEM_TIMEOUT_EN
        cyc(IN_DST,   EX_S0,   1'b1);
        repeat (7) cyc(IN_DST, EX_S1, 1'b1);
        cyc(IN_DST,   EX_TO,   1'b1);
        cyc(IN_IDLE,  EX_FL2,  1'b1);
        cyc(IN_IDLE,  EX_N,    1'b1);
`endif
        repeat (3) cyc(IN_IDLE, EX_N, 1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msrv32_pipe_ctrl.md
# msrv32_pipe_ctrl

Pipeline sequencing controller for the msrv32 RV32I core. Generates the enable and flush (bubble-insert) controls for the PC register, the stage-1 register block and the stage-2 register block. Resolves four conditions by fixed priority: taken branches, traps, data-memory wait states and load-use hazards. Sits beside the stage-2/3 boundary and is the only source of stall and flush decisions in the core.

## Interface
- FLUSH_CYCLES, default 1: bubble cycles inserted per redirect; legal range 1..15.
- TIMEOUT_W, default 8: width of the memory-wait timeout counter; used only with the macro.

Ports:
- clk_in  input  1  single core clock.
- reset_in  input  1  synchronous, active-low reset; sampled on the rising edge of clk_in.
- branch_taken_in  input  1  stage-3 branch/jump redirect this cycle.
- trap_taken_in  input  1  trap/interrupt redirect request; held by trap logic until trap_ack_out.
- dmem_req_in  input  1  stage-3 instruction accesses data memory.
- dmem_ready_in  input  1  data memory completes the access this cycle.
- imem_ready_in  input  1  fetch data valid this cycle.
- load_use_in  input  1  stage-2 source register matches the rd of a stage-3 load.
- pc_en_out  output  1  PC register load enable.
- reg1_en_out  output  1  stage-1 register block enable.
- reg1_flush_out  output  1  load a NOP into stage 1.
- reg2_en_out  output  1  stage-2 register block enable.
- reg2_flush_out  output  1  load a NOP into stage 2 (clears rf_wr_en and csr_wr_en).
- trap_ack_out  output  1  one-cycle pulse; the trap redirect is applied this cycle.
- state_out  output  2  current FSM state, for debug.
- mem_timeout_out  output  1  memory-wait timeout pulse; tied 0 without the macro.

## Operation
- **States:** RUN=0, MEM_WAIT=1, FLUSH=2. State 3 is illegal and recovers to RUN on the next edge.
- **Redirect:** redir = trap_taken_in | branch_taken_in. A flush is a cycle with reg1_flush_out=reg2_flush_out=1 and both register enables at 1.
- **RUN priority, highest first:**
  1. redir: pc_en_out=1, flush. trap_ack_out=trap_taken_in. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  2. dmem_req_in & !dmem_ready_in: all enables 0, no flush; go to MEM_WAIT.
  3. load_use_in: pc_en_out=0, reg1_en_out=0, reg2_en_out=1, reg2_flush_out=1. Stay in RUN.
  4. !imem_ready_in: pc_en_out=0, reg1_en_out=1, reg1_flush_out=1, reg2_en_out=1.
  5. Otherwise all enables 1, no flush.
- **MEM_WAIT:**
  - All enables 0.
  - trap_taken_in sets trap_pend; branch_taken_in is ignored.
  - On dmem_ready_in: all enables 1, then return to RUN. If trap_pend was set, the next RUN cycle applies the trap redirect.
- **FLUSH:**
  - pc_en_out=imem_ready_in, flush outputs asserted.
  - cnt decrements each cycle; return to RUN when cnt reaches 0.
  - A new redir in FLUSH reloads cnt=FLUSH_CYCLES-1 and asserts pc_en_out=1.
- **Simultaneous branch and trap:** the trap wins. pc_en_out=1 and trap_ack_out=1.
- **Reset asserted (reset_in=0):**
  - Outputs are forced: pc_en_out=0, reg1_en_out=reg2_en_out=1, both flush outputs=1, trap_ack_out=0, mem_timeout_out=0.
  - On the next edge: state=RUN, cnt=0, trap_pend=0, timer=0.
  - Reset mid-MEM_WAIT or mid-FLUSH abandons the operation; there is no pending trap after reset.

## Timing
- Outputs are combinational from state and inputs; state, cnt, trap_pend and timer are registered.
- **Redirect to first refetched instruction in stage 2:** FLUSH_CYCLES+1 cycles.
- **Load-use:** exactly one bubble; load_use_in must drop the next cycle.
- **MEM_WAIT exit:** the pipeline advances in the same cycle dmem_ready_in is high. A ready arriving in the request cycle causes no stall.
- **trap_ack_out:** pulses exactly once per trap. trap_taken_in must drop the cycle after the ack.

## Configuration
- **MSRV32_MEM_TIMEOUT_EN defined:**
  - A TIMEOUT_W-bit timer counts consecutive MEM_WAIT cycles and clears on leaving MEM_WAIT.
  - On reaching all-ones with dmem_ready_in still low: mem_timeout_out pulses for 1 cycle and the FSM goes to FLUSH, with cnt=FLUSH_CYCLES-1 and pc_en_out=0.
  - Trap logic then raises an access fault.
- **Not defined:** the timer is absent, mem_timeout_out is tied 0, and MEM_WAIT waits indefinitely.

## Structure
- **Package msrv32_pkg:** state encodings RUN/MEM_WAIT/FLUSH (2-bit localparams) and the FLUSH_CYCLES range limit.
- **Sub-module msrv32_wait_timer:** wraps the timeout counter with clear/enable/expire ports. It is instantiated only under MSRV32_MEM_TIMEOUT_EN.

## Test plan
- **Reset:** hold reset_in=0 for 3 cycles.
  - Expect pc_en_out=0, both flushes=1, trap_ack_out=0.
  - After release, state_out=0.
- **Branch:** branch_taken_in=1 for 1 cycle with FLUSH_CYCLES=2.
  - Expect pc_en_out=1, flushes high for 2 cycles, state_out=2 for 1 cycle, then RUN.
- **Memory wait with trap:** dmem_req_in=1, dmem_ready_in=0 for 4 cycles; trap_taken_in=1 raised in wait cycle 2.
  - Expect all enables 0 for 4 cycles.
  - On ready, enables 1; the next cycle gives trap_ack_out=1 and pc_en_out=1.
- **Load-use:** load_use_in=1 for 1 cycle.
  - Expect pc_en_out=0, reg1_en_out=0, reg2_flush_out=1, then normal flow.
- **Simultaneous redirects:** branch_taken_in=1 and trap_taken_in=1 in the same cycle.
  - Expect a single trap_ack_out pulse, pc_en_out=1, and one flush sequence.
- **Timeout (macro on, TIMEOUT_W=3):** dmem_ready_in held 0.
  - Expect mem_timeout_out pulse after 7 MEM_WAIT cycles, then state_out=2.
